rom_download_bridge: RTL and testbench

//  Sits between the HPS/sim ioctl download port and the core's dn_addr/dn_data/dn_wr ROM-load bus.

---
 rtl/rom_download_bridge.sv | 141 ++++++++++++++
 tb/tb_rom_download_bridge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_bridge.sv
// Bridges the ioctl download port onto the core's dn_* ROM-load bus.
// Bytes are buffered in a small FIFO, replayed as spaced strobes, and the core is held in reset during the load.
module rom_download_bridge #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned ROM_INDEX  = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_GAP     = 2,
  parameter int unsigned HOLD_CYC   = 16
) (
  input  logic              clk_12mhz,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_write,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              dl_done,
  output logic [24:0]       byte_count,
  output logic [7:0]        checksum,
  output logic              err_overflow,
  output logic              err_range
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + 8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;
  state_t state, state_d;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       gap_cnt;
  logic [15:0]      hold_cnt;
  logic active, active_q, start, range_ok, full, empty, wr_hit, push, pop, finishing;

  assign active    = ioctl_download && (ioctl_index == 8'(ROM_INDEX));
  assign start     = active && !active_q;
  assign range_ok  = (ioctl_addr >> ADDR_W) == 25'd0;
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (fifo_count == '0);
  assign wr_hit    = ioctl_write && active;
  assign push      = wr_hit && range_ok && !full;
  assign pop       = (state == S_WRITE);
  assign head      = fifo_mem[rd_ptr];
  assign finishing = core_reset && !active && empty && (state == S_IDLE);

  // Leaving IDLE on the push itself gives the two-cycle write-to-strobe latency.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (push || !empty) state_d = S_WRITE;
      S_WRITE: state_d = (WR_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_cnt == 4'(WR_GAP - 1)) state_d = (empty && !push) ? S_IDLE : S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : '0;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (push) fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  end

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      ioctl_wait   <= 1'b0;
      dn_addr      <= '0;
      dn_data      <= '0;
      dn_wr        <= 1'b0;
      core_reset   <= 1'b0;
      dl_done      <= 1'b0;
      hold_cnt     <= '0;
      byte_count   <= '0;
      checksum     <= '0;
      err_overflow <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      active_q <= active;
      dl_done  <= 1'b0;
      dn_wr    <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        dn_addr <= head[ENT_W-1:8];
        dn_data <= head[7:0];
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      ioctl_wait <= (fifo_count >= CNT_W'(FIFO_DEPTH - 1)) ||
                    ((fifo_count == CNT_W'(FIFO_DEPTH - 2)) && push);

      if (finishing) begin
        if (hold_cnt == 16'(HOLD_CYC - 1)) begin
          core_reset <= 1'b0;
          dl_done    <= 1'b1;
          hold_cnt   <= '0;
        end else begin
          hold_cnt <= hold_cnt + 16'd1;
        end
      end else begin
        hold_cnt <= '0;
      end

      // A restart keeps FIFO contents but restarts statistics and the hold window.
      if (start) begin
        byte_count   <= '0;
        checksum     <= '0;
        err_overflow <= 1'b0;
        err_range    <= 1'b0;
        core_reset   <= 1'b1;
      end else if (pop) begin
        byte_count <= byte_count + 25'd1;
        checksum   <= checksum + head[7:0];
      end
      if (wr_hit && !range_ok) err_range <= 1'b1;
      if (wr_hit && range_ok && full) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rom_download_bridge.sv
// Scoreboard bench for rom_download_bridge: stimulus queues expected bytes, a monitor checks each dn_wr strobe.
`timescale 1ns/1ps
module tb_rom_download_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_write = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr, core_reset, dl_done, err_overflow, err_range;
  logic [24:0] byte_count;
  logic [7:0]  checksum;

  rom_download_bridge #(.ADDR_W(16), .ROM_INDEX(0), .FIFO_DEPTH(4), .WR_GAP(2), .HOLD_CYC(16)) dut (
    .clk_12mhz(clk), .reset_n(rst_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_write(ioctl_write), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .core_reset(core_reset), .dl_done(dl_done),
    .byte_count(byte_count), .checksum(checksum), .err_overflow(err_overflow), .err_range(err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_tests = 0, n_fail = 0;
  int         n_wr = 0, n_done = 0, done_cyc = 0, last_wr_cyc = -1, skipped = 0;
  logic [7:0] sum_wr = '0;
  bit         lat_chk = 0, gap_chk = 0, skip_mode = 0, wait_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding byte.
  always @(negedge clk) begin
    if (rst_n && dn_wr) begin
      if (skip_mode)
        while (exp_q.size() > 0 && (exp_q[0].addr != dn_addr || exp_q[0].data != dn_data)) begin
          exp_q.delete(0);
          skipped++;
        end
      check("dn_wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("dn_addr", dn_addr, mon_e.addr);
        check("dn_data", dn_data, mon_e.data);
        if (lat_chk) check("wr_latency", cyc - mon_e.cyc, 2);
      end
      if (gap_chk && last_wr_cyc >= 0) check("wr_spacing", cyc - last_wr_cyc, 3);
      last_wr_cyc = cyc;
      n_wr++;
      sum_wr += dn_data;
    end
    if (rst_n && dl_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit keep);
    exp_t e;
    ioctl_write = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    if (keep) begin
      e.addr = a[15:0];
      e.data = d;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    tick(1);
    ioctl_write = 1'b0;
  endtask

  task automatic wr_honour(input logic [24:0] a, input logic [7:0] d);
    int w = 0;
    while (ioctl_wait && w < 50) begin
      wait_seen = 1;
      tick(1);
      w++;
    end
    if (w >= 50) check("wait_bound", w, 0);
    wr(a, d, 1);
  endtask

  task automatic start_session(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    n_wr = 0; sum_wr = '0; skipped = 0; last_wr_cyc = -1; wait_seen = 0;
    tick(1);
  endtask

  task automatic end_session(output int dcyc);
    int n0 = n_done;
    int w = 0;
    ioctl_download = 1'b0;
    dcyc = cyc;
    while (n_done == n0 && w < 80) begin
      tick(1);
      w++;
    end
    check("dl_done_seen", n_done - n0, 1);
    check("core_reset_released", core_reset, 0);
    check("dl_done_single", dl_done, 0);
  endtask

  initial begin
    int         dcyc, n0, nb, dropped;
    logic [7:0] msum, d;
    logic [7:0] dbyte;

    #1;
    check("reset_outputs", {ioctl_wait, dn_addr, dn_data, dn_wr, core_reset, dl_done,
                            byte_count, checksum, err_overflow, err_range}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1) four spaced writes, fixed data
    start_session(8'd0);
    check("core_reset_on", core_reset, 1);
    lat_chk = 1;
    msum = '0;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      msum += d;
      wr(25'(i), d, 1);
      tick(15);
    end
    lat_chk = 0;
    check("t1_n_wr", n_wr, 4);
    check("t1_byte_count", byte_count, 4);
    check("t1_checksum", checksum, msum);
    end_session(dcyc);
    check("t1_done_delay", done_cyc - dcyc, 16);

    // 2) back-to-back burst honouring ioctl_wait
    start_session(8'd0);
    gap_chk = 1;
    msum = '0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      msum += d;
      wr_honour(25'($urandom_range(0, 16'hFFFF)), d);
    end
    tick(40);
    gap_chk = 0;
    check("t2_n_wr", n_wr, 8);
    check("t2_byte_count", byte_count, 8);
    check("t2_checksum", checksum, msum);
    check("t2_no_overflow", err_overflow, 0);
    check("t2_wait_seen", wait_seen, 1);
    check("t2_queue_drained", exp_q.size(), 0);
    end_session(dcyc);

    // 3) same burst ignoring ioctl_wait
    start_session(8'd0);
    skip_mode = 1;
    for (int i = 0; i < 8; i++) wr(25'(16'h0100 + i), 8'($urandom), 1);
    tick(40);
    skip_mode = 0;
    dropped = skipped + exp_q.size();
    exp_q.delete();
    check("t3_overflow", err_overflow, 1);
    check("t3_partial", byte_count < 8, 1);
    check("t3_count_vs_strobes", byte_count, n_wr);
    check("t3_accounted", n_wr + dropped, 8);
    check("t3_checksum", checksum, sum_wr);
    end_session(dcyc);

    // random sessions, source honours ioctl_wait with random pacing
    for (int s = 0; s < 3; s++) begin
      start_session(8'd0);
      nb = $urandom_range(5, 12);
      msum = '0;
      for (int i = 0; i < nb; i++) begin
        dbyte = 8'($urandom);
        msum += dbyte;
        tick($urandom_range(0, 4));
        wr_honour(25'($urandom_range(0, 16'hFFFF)), dbyte);
      end
      tick(50);
      check("rnd_n_wr", n_wr, nb);
      check("rnd_byte_count", byte_count, nb);
      check("rnd_checksum", checksum, msum);
      check("rnd_errors", {err_overflow, err_range}, 0);
      end_session(dcyc);
    end

    // 4) foreign index is ignored
    n0 = n_done;
    start_session(8'd1);
    for (int i = 0; i < 4; i++) begin
      wr(25'(i), 8'($urandom), 0);
      tick(2);
    end
    tick(20);
    check("t4_no_wr", n_wr, 0);
    check("t4_core_reset", core_reset, 0);
    check("t4_no_flags", {err_overflow, err_range}, 0);
    ioctl_download = 1'b0;
    tick(40);
    check("t4_no_done", n_done - n0, 0);

    // 5) out-of-range address dropped, next write delivered
    start_session(8'd0);
    wr(25'h010000, 8'($urandom), 0);
    tick(10);
    check("t5_err_range", err_range, 1);
    check("t5_dropped", n_wr, 0);
    dbyte = 8'($urandom);
    wr(25'h000005, dbyte, 1);
    tick(10);
    check("t5_n_wr", n_wr, 1);
    check("t5_byte_count", byte_count, 1);
    check("t5_checksum", checksum, dbyte);
    check("t5_range_sticky", err_range, 1);
    end_session(dcyc);

    // 6) async reset mid-burst with two bytes buffered
    start_session(8'd0);
    for (int i = 0; i < 3; i++) wr(25'(i), 8'($urandom), 1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {ioctl_wait, dn_addr, dn_data, dn_wr, core_reset, dl_done,
                               byte_count, checksum, err_overflow, err_range}, 0);
    exp_q.delete();
    ioctl_download = 1'b0;
    n_wr = 0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("t6_no_stale_wr", n_wr, 0);
    check("t6_core_reset", core_reset, 0);
    check("t6_byte_count", byte_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
